// File: rtl/sad_addr_seq_if.sv
// Handshake bundle between the SAD controller (master) and the address sequencer (slave).
// A beat transfers on a rising edge where valid && ready; valid never depends on ready and a beat holds until accepted.
interface sad_addr_seq_if #(
    parameter int ADDR_W = 9,
    parameter int STEP   = 1
);
    localparam int LANE_W = $clog2(STEP) + 1;

    logic              start;
    logic [ADDR_W-1:0] len;
    logic              ready;
    logic [ADDR_W-1:0] AB_addr;
    logic              valid;
    logic              comp;
    logic              first;
    logic              last;
    logic [LANE_W-1:0] beat_lanes;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    modport master (
        output start, len, ready,
        input  AB_addr, valid, comp, first, last, beat_lanes, busy, done, state_dbg
    );

    modport slave (
        input  start, len, ready,
        output AB_addr, valid, comp, first, last, beat_lanes, busy, done, state_dbg
    );
endinterface

// File: rtl/sad_addr_seq.sv
// Address sequencer for the SAD datapath: sweeps A/B memory addresses 0..len-1, STEP per beat.
// All outputs derive from the state, address and length registers only.
module sad_addr_seq #(
    parameter int ADDR_W  = 9,
    parameter int MAX_LEN = 256,
    parameter int STEP    = 1
) (
    input logic          clk,
    input logic          rst,
    sad_addr_seq_if.slave bus
);
    localparam int LANE_W = $clog2(STEP) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W:0]   addr_sum;
    logic              run_valid;
    logic              last_beat;
    logic              accept;
    logic              launch;
    logic [ADDR_W-1:0] len_clamped;

    // One extra bit on the sum so addr + STEP cannot wrap past len_q.
    assign addr_sum    = {1'b0, addr_q} + (ADDR_W+1)'(STEP);
    assign run_valid   = (state_q == RUN);
    assign last_beat   = run_valid && (addr_sum >= {1'b0, len_q});
    assign accept      = run_valid && bus.ready;
    assign launch      = (state_q == IDLE) && bus.start;
    assign len_clamped = (bus.len > ADDR_W'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : bus.len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
        end else if (launch) begin
            addr_q <= '0;
            len_q  <= len_clamped;
        end else if (accept && !last_beat) begin
            addr_q <= addr_sum[ADDR_W-1:0];
        end
    end

    assign bus.AB_addr    = addr_q;
    assign bus.valid      = run_valid;
    assign bus.comp       = run_valid && (addr_q < len_q);
    assign bus.first      = run_valid && (addr_q == '0);
    assign bus.last       = last_beat;
    assign bus.beat_lanes = !run_valid ? '0 :
                            last_beat  ? LANE_W'(len_q - addr_q) : LANE_W'(STEP);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.state_dbg  = state_q;
endmodule

// File: doc/sad_addr_seq.md
# sad_addr_seq

Parametrised address sequencer for the SAD datapath. On a start command it walks the A/B block memories from address 0 up to a programmable length, `STEP` elements per beat, under a valid/ready handshake. It produces the in-range compare flag `comp`, first/last markers, a lane count for partial final beats, and a one-cycle `done`. It sits between the SAD controller FSM and the A/B memory read ports.

## Interface
- `ADDR_W`, 9: width of `AB_addr` and `len`.
- `MAX_LEN`, 256: largest legal block length; must be ≤ 2**ADDR_W − 1.
- `STEP`, 1: elements fetched per beat (address increment); power of two, 1..16.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch a sweep; sampled only in IDLE.
- `len`  in  ADDR_W  number of elements to sweep; sampled with `start`.
- `ready`  in  1  consumer accepts the current beat.
- `AB_addr`  out  ADDR_W  element address of the current beat's first lane.
- `valid`  out  1  `AB_addr` holds a beat to be consumed.
- `comp`  out  1  `valid && AB_addr < len_q` (in-range flag).
- `first`  out  1  current beat is beat 0.
- `last`  out  1  current beat is the final beat.
- `beat_lanes`  out  $clog2(STEP)+1  valid lanes in the current beat (1..STEP).
- `busy`  out  1  state is RUN or DONE.
- `done`  out  1  one-cycle pulse after the sweep completes.

## Operation
- Reset values: `AB_addr`=0, `valid`=0, `comp`=0, `first`=0, `last`=0, `beat_lanes`=0, `busy`=0, `done`=0. Internal `len_q`=0. State is IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 with `len`=0: go to DONE with no beats issued.
  - `start`=1 with `len`>0: `len_q` = min(`len`, `MAX_LEN`), `AB_addr`=0, go to RUN.
- RUN:
  - `valid`=1.
  - On `valid && ready`: `AB_addr` += `STEP`.
  - If the accepted beat has `last`=1, go to DONE instead of incrementing.
  - `ready`=0 holds all outputs stable.
- DONE: `done`=1 and `valid`=0 for exactly one cycle, then IDLE.
- `last` = (`AB_addr` + `STEP` ≥ `len_q`).
- `beat_lanes` = `last` ? (`len_q` − `AB_addr`) : `STEP`; 0 when `valid`=0.
- `first` = `valid && AB_addr`==0.
- Arithmetic: the address sum is computed at ADDR_W+1 bits, so wrap-around is impossible. `AB_addr` never presents a value ≥ `len_q`, so `comp` equals `valid` in legal use.
- `start` in RUN or DONE is ignored; no queuing.
- `len` changes after sampling have no effect.
- `rst` in any state wins over all other inputs. Outputs take their reset values at the next edge and any in-flight sweep is abandoned with no `done`.

## Timing
- `start` sampled at edge N: the first beat is valid from N+1. For `len`=0, `done`=1 at N+1.
- Throughput: one beat per cycle while `ready`=1.
- Last beat accepted at edge M: `done`=1 during M+1 → M+2. Earliest next `start` sample is edge M+2 (IDLE).
- All outputs are registered or derived only from registered state. There is no combinational path from `ready`/`start` to any output.
- Sweep length with `ready` held high: ceil(`len_q`/`STEP`) beats + 1 DONE cycle.

## Test plan
- Default params, `len`=37, `ready`=1: `AB_addr` 0..36 on 37 consecutive cycles. `first` on 0, `last` on 36, `comp`=1 throughout, `done` the cycle after 36, `busy` falls the cycle after that.
- `len`=256 and then `len`=300 (clamped):
  - Both give addresses 0..255 and `last` at 255.
  - `AB_addr` never shows 256; `comp`=0 once `valid` drops.
- `len`=20 with `ready` toggling 1,0,0,1,… at address 5: `AB_addr` holds at 5 while `ready`=0. No beat is skipped or duplicated, and `done` follows acceptance of 19.
- `STEP`=4, `len`=10: beats at 0, 4, 8 with `beat_lanes` 4, 4, 2. `last` on 8, `done` one cycle after.
- `len`=0 `start`: `done`=1 the next cycle, `valid` never rises.
  - Also assert `start` during RUN with a different `len`: it is ignored and the sweep completes with the original length.
- `rst` at `AB_addr`=100 of a 200-element sweep: all outputs 0 at the next edge and no `done`. A fresh `start` with `len`=3 then runs 0, 1, 2 normally.
